// File: rtl/i2s_tx.sv
// I2S transmitter: generates bclk/lrc and shifts out stereo PCM frames
// MSB first with a one-bit delay after each lrc edge; one-frame buffer.
module i2s_tx #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int DIV    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              bclk,
  output logic              lrc,
  output logic              dat,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BW = $clog2(FRAME_W);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] SLOT = BW'(SLOT_W);
  localparam logic [BW-1:0] DLEN = BW'(DATA_W);
  localparam logic [DW-1:0] DTOP = DW'(DIV - 1);

  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     nxt_bit;
  logic [BW-1:0]     pos;
  logic              buf_full;
  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic              wrap;
  logic              fall;
  logic              load;
  logic              right;
  logic              data_bit;
  logic              xfer;

  assign in_ready = ~buf_full;

  always_comb begin
    wrap     = en && (div_cnt == DTOP);
    fall     = wrap && bclk;
    nxt_bit  = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    load     = fall && (nxt_bit == '0);
    right    = (nxt_bit >= SLOT);
    pos      = right ? nxt_bit - SLOT : nxt_bit;
    data_bit = (pos != '0) && (pos <= DLEN);
    xfer     = in_valid && !buf_full;
  end

  // a transfer colliding with a load of an empty buffer waits a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else if (xfer) begin
      buf_full <= 1'b1;
      buf_l    <= in_left;
      buf_r    <= in_right;
    end else if (load && buf_full) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      bit_cnt     <= LAST;
      bclk        <= 1'b0;
      lrc         <= 1'b1;
      dat         <= 1'b0;
      sh_l        <= '0;
      sh_r        <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (!en) begin
      div_cnt     <= '0;
      bit_cnt     <= LAST;
      bclk        <= 1'b0;
      lrc         <= 1'b1;
      dat         <= 1'b0;
      sh_l        <= '0;
      sh_r        <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      div_cnt     <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) begin
        bclk <= ~bclk;
      end
      if (fall) begin
        bit_cnt <= nxt_bit;
        lrc     <= right;
        dat     <= 1'b0;
        if (load) begin
          frame_start <= 1'b1;
          underrun    <= ~buf_full;
          sh_l        <= buf_full ? buf_l : '0;
          sh_r        <= buf_full ? buf_r : '0;
        end else if (data_bit && right) begin
          dat  <= sh_r[DATA_W-1];
          sh_r <= sh_r << 1;
        end else if (data_bit) begin
          dat  <= sh_l[DATA_W-1];
          sh_l <= sh_l << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized scoreboard bench for i2s_tx: a buffer model predicts each
// frame, an I2S receiver model captures dat and compares.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        bclk;
  logic        lrc;
  logic        dat;
  logic        frame_start;
  logic        underrun;

  i2s_tx dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left(in_left),
    .in_right(in_right),
    .bclk(bclk),
    .lrc(lrc),
    .dat(dat),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } frm_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int fs_cyc = 0;
  int nfr = 0;

  logic [31:0] acc[$];
  frm_t        exp_q[$];
  frm_t        f;
  logic        pend_v = 1'b0;
  logic [31:0] pend = '0;
  logic        en_d = 1'b0;
  logic        bclk_q = 1'b0;
  logic        lrc_q = 1'b1;
  logic        synced = 1'b0;
  int          pos = 0;
  int          last_fs = -1;
  int          last_rise = -1;
  logic [15:0] word = '0;
  logic [15:0] cap_l = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  // model: one-entry buffer, frame loads pop it, transfers land after
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_bclk", bclk, 0);
      chk("rst_lrc", lrc, 1);
      chk("rst_dat", dat, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_fs", frame_start, 0);
      chk("rst_ur", underrun, 0);
      acc.delete();
      exp_q.delete();
      pend_v = 1'b0;
      synced = 1'b0;
      lrc_q = 1'b1;
      last_fs = -1;
      last_rise = -1;
    end else begin
      if (!en_d) begin
        chk("idle_bclk", bclk, 0);
        chk("idle_lrc", lrc, 1);
        chk("idle_dat", dat, 0);
        chk("idle_fs", frame_start, 0);
        exp_q.delete();
        synced = 1'b0;
        lrc_q = 1'b1;
        last_fs = -1;
        last_rise = -1;
      end
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, 256);
        last_fs = cyc;
        fs_cyc = cyc;
        chk("lrc_at_fs", lrc, 0);
        if (acc.size() > 0) begin
          pend_v = pend_v;
          f.l = acc[0][31:16];
          f.r = acc[0][15:0];
          void'(acc.pop_front());
          chk("underrun", underrun, 0);
        end else begin
          f.l = '0;
          f.r = '0;
          chk("underrun", underrun, 1);
        end
        exp_q.push_back(f);
      end else begin
        chk("underrun_spurious", underrun, 0);
      end
      if (pend_v) acc.push_back(pend);
      chk("in_ready", in_ready, (acc.size() == 0) ? 1 : 0);
      if (bclk && !bclk_q) begin
        if (last_rise >= 0) chk("bclk_period", cyc - last_rise, 4);
        last_rise = cyc;
        if (lrc != lrc_q) begin
          synced = 1'b1;
          pos = 0;
        end else begin
          pos++;
        end
        lrc_q = lrc;
        if (synced) begin
          if (pos >= 1 && pos <= 16) word = {word[14:0], dat};
          else chk("pad_zero", dat, 0);
          if (pos == 16 && !lrc) cap_l = word;
          if (pos == 16 && lrc) begin
            if (exp_q.size() == 0) begin
              chk("frame_expected", exp_q.size(), 1);
            end else begin
              f = exp_q.pop_front();
              chk("left", cap_l, f.l);
              chk("right", word, f.r);
              nfr++;
            end
          end
        end
      end
    end
    bclk_q = bclk;
    pend_v = reset && in_valid && (acc.size() == 0);
    pend = {in_left, in_right};
    en_d = en;
  end

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(posedge clk);
    #2;
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && !in_ready; i++) begin
      @(posedge clk);
      #2;
    end
    chk("push_timeout", in_ready, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_start && t < 600);
    chk("fs_timeout", frame_start, 1);
  endtask

  task automatic set_en(input logic v);
    @(posedge clk);
    #2;
    en = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] k;
    logic        rdy;
    int          n0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      en = 1'($urandom);
      in_valid = 1'($urandom);
      in_left = 16'($urandom);
      in_right = 16'($urandom);
    end
    en = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    push(16'hA5F0, 16'h0F0F);
    set_en(1'b1);
    wait_fs();
    repeat (3) wait_fs();

    push(16'h8001, 16'h7FFF);
    wait_fs();
    repeat (255) @(posedge clk);
    #2;
    in_left = 16'($urandom);
    in_right = 16'($urandom);
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("coll_fs", frame_start, 1);
    chk("coll_ur", underrun, 1);
    chk("coll_held", in_ready, 0);
    repeat (2) wait_fs();

    push(16'($urandom), 16'($urandom));
    wait_fs();
    push(16'($urandom), 16'($urandom));
    while (cyc < fs_cyc + 160) @(posedge clk);
    #2;
    en = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    chk("dis_held", in_ready, 0);
    en = 1'b1;
    repeat (2) wait_fs();

    repeat (20 * 256) begin
      @(posedge clk);
      #2;
      in_valid = ($urandom_range(0, 3) == 0);
      in_left = 16'($urandom);
      in_right = 16'($urandom);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;

    k = 16'($urandom);
    in_left = k;
    in_right = ~k;
    in_valid = 1'b1;
    n0 = nfr;
    repeat (101 * 256) begin
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        k = k + 16'd1;
        in_left = k;
        in_right = ~k;
      end
    end
    in_valid = 1'b0;
    chk("stream_frames", (nfr - n0 >= 100) ? 1 : 0, 1);
    set_en(1'b0);
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
